config_chain_loader: RTL and testbench



---
 rtl/config_chain_loader_if.sv | 11 +
 rtl/config_chain_loader.sv | 188 ++++++++++++++++++
 tb/tb_config_chain_loader.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_chain_loader_if.sv
// Host word stream between the bitstream source and the configuration chain loader.
interface config_chain_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  word_valid;
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_ready;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/config_chain_loader.sv
// Serialises host words MSB-first onto a tile configuration chain after clearing it.
// Optional CRC-8 check of the loaded bits is compiled in with CONFIG_CHAIN_CRC_EN.
module config_chain_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 64,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 start,
  input  logic                 abort,
  config_chain_loader_if.slave bus,
  output logic                 cfg_nreset,
  output logic                 cfg_enable,
  output logic                 cfg_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);
  localparam int                     BIT_W     = $clog2(WORD_WIDTH);
  localparam logic [BIT_W-1:0]       LAST_BIT  = BIT_W'(WORD_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] CHAIN_END = COUNT_WIDTH'(CHAIN_LENGTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_WAIT_WORD = 3'd2,
`ifdef CONFIG_CHAIN_CRC_EN
    ST_SHIFT     = 3'd3,
    ST_CHECK     = 3'd4
`else
    ST_SHIFT     = 3'd3
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  holder_q, holder_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   word_ready_q, word_ready_d;
  logic                   cfg_nreset_q, cfg_nreset_d;
  logic                   cfg_enable_q, cfg_enable_d;
  logic                   cfg_data_q, cfg_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

`ifdef CONFIG_CHAIN_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  // Next state and next register values; outputs are decoded from the next state
  always_comb begin
    state_d  = state_q;
    holder_d = holder_q;
    bit_d    = bit_q;
    count_d  = count_q;
    error_d  = error_q;
    done_d   = 1'b0;
`ifdef CONFIG_CHAIN_CRC_EN
    crc_d    = crc_q;
`endif
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      error_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d = ST_CLEAR;
            error_d = 1'b0;
            count_d = '0;
`ifdef CONFIG_CHAIN_CRC_EN
            crc_d   = 8'h00;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CLEAR: state_d = ST_WAIT_WORD;
        ST_WAIT_WORD: begin
          if (bus.word_valid && word_ready_q) begin
            holder_d = bus.word_data;
            bit_d    = '0;
            state_d  = ST_SHIFT;
          end else begin
            state_d = ST_WAIT_WORD;
          end
        end
        ST_SHIFT: begin
          holder_d = {holder_q[WORD_WIDTH-2:0], 1'b0};
          bit_d    = bit_q + BIT_W'(1);
          count_d  = count_q + COUNT_WIDTH'(1);
`ifdef CONFIG_CHAIN_CRC_EN
          crc_d    = crc8_step(crc_q, holder_q[WORD_WIDTH-1]);
`endif
          // Chain end takes priority: low bits of a partial last word are dropped
          if (count_d == CHAIN_END) begin
`ifdef CONFIG_CHAIN_CRC_EN
            state_d = ST_CHECK;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else if (bit_q == LAST_BIT) begin
            state_d = ST_WAIT_WORD;
          end else begin
            state_d = ST_SHIFT;
          end
        end
`ifdef CONFIG_CHAIN_CRC_EN
        ST_CHECK: begin
          if (bus.word_valid && word_ready_q) begin
            state_d = ST_IDLE;
            if (8'(bus.word_data) == crc_q) begin
              done_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end else begin
            state_d = ST_CHECK;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end

`ifdef CONFIG_CHAIN_CRC_EN
    word_ready_d = (state_d == ST_WAIT_WORD) || (state_d == ST_CHECK);
`else
    word_ready_d = (state_d == ST_WAIT_WORD);
`endif
    cfg_nreset_d = (state_d != ST_CLEAR);
    cfg_enable_d = (state_d == ST_SHIFT);
    cfg_data_d   = (state_d == ST_SHIFT) ? holder_d[WORD_WIDTH-1] : 1'b0;
    busy_d       = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      holder_q     <= '0;
      bit_q        <= '0;
      count_q      <= '0;
      word_ready_q <= 1'b0;
      cfg_nreset_q <= 1'b1;
      cfg_enable_q <= 1'b0;
      cfg_data_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef CONFIG_CHAIN_CRC_EN
      crc_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      holder_q     <= holder_d;
      bit_q        <= bit_d;
      count_q      <= count_d;
      word_ready_q <= word_ready_d;
      cfg_nreset_q <= cfg_nreset_d;
      cfg_enable_q <= cfg_enable_d;
      cfg_data_q   <= cfg_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef CONFIG_CHAIN_CRC_EN
      crc_q        <= crc_d;
`endif
    end
  end

  assign bus.word_ready = word_ready_q;
  assign cfg_nreset     = cfg_nreset_q;
  assign cfg_enable     = cfg_enable_q;
  assign cfg_data       = cfg_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: three instances (chain lengths 16, 20 and 8, 8-bit words).
`timescale 1ns/1ps
module tb_config_chain_loader;
  localparam int NDUT = 3;

  function automatic int cl_of(input int i);
    return (i == 0) ? 16 : ((i == 1) ? 20 : 8);
  endfunction

  logic       clk = 1'b0;
  logic       nreset;
  logic       start_s [NDUT];
  logic       abort_s [NDUT];
  logic       valid_s [NDUT];
  logic [7:0] data_s  [NDUT];

  wire ready_w      [NDUT];
  wire cfg_nreset_w [NDUT];
  wire en_w         [NDUT];
  wire data_w       [NDUT];
  wire busy_w       [NDUT];
  wire done_w       [NDUT];
  wire err_w        [NDUT];

  int total = 0;
  int bad   = 0;
  int          en_cnt   [NDUT] = '{default: 0};
  int          done_cnt [NDUT] = '{default: 0};
  int          clr_cnt  [NDUT] = '{default: 0};
  logic [31:0] cap      [NDUT] = '{default: 32'h0};
  logic        exp_q    [NDUT][$];

  typedef struct {
    int          dut;
    int          nw;
    logic [23:0] words;
    int          stall;
    int          exp_en;
    logic [31:0] exp_seq;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    config_chain_loader_if #(.WORD_WIDTH(8)) bus ();
    assign bus.word_valid = valid_s[g];
    assign bus.word_data  = data_s[g];
    assign ready_w[g]     = bus.word_ready;

    config_chain_loader #(
      .WORD_WIDTH  (8),
      .CHAIN_LENGTH(cl_of(g)),
      .COUNT_WIDTH (16)
    ) dut (
      .clock     (clk),
      .nreset    (nreset),
      .start     (start_s[g]),
      .abort     (abort_s[g]),
      .bus       (bus),
      .cfg_nreset(cfg_nreset_w[g]),
      .cfg_enable(en_w[g]),
      .cfg_data  (data_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .error     (err_w[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef CONFIG_CHAIN_CRC_EN
  function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction
`endif

  // Scoreboard: pop one expected bit per enabled chain cycle; count clears and done pulses
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (nreset === 1'b1) begin
        if (en_w[i] === 1'b1) begin
          en_cnt[i] = en_cnt[i] + 1;
          cap[i]    = {cap[i][30:0], data_w[i]};
          check("enable_with_ready", ready_w[i], 1'b0);
          if (exp_q[i].size() != 0) begin
            logic eb;
            eb = exp_q[i].pop_front();
            check("cfg_data", data_w[i], eb);
          end else begin
            check("unexpected_bit_queue_size", exp_q[i].size(), 1);
          end
        end
        if (done_w[i] === 1'b1) begin
          done_cnt[i] = done_cnt[i] + 1;
          check("busy_with_done", busy_w[i], 1'b0);
        end
        if (cfg_nreset_w[i] === 1'b0) clr_cnt[i] = clr_cnt[i] + 1;
      end
    end
  end

  task automatic wait_ready(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (ready_w[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic present(input int i, input logic [7:0] w);
    valid_s[i] = 1'b1;
    data_s[i]  = w;
    tick();
    valid_s[i] = 1'b0;
    check("enable_after_accept", en_w[i], 1'b1);
    check("ready_after_accept", ready_w[i], 1'b0);
  endtask

  task automatic run_load(input int i, input int nw, input logic [23:0] words, input int stall,
                          input int exp_en, input logic [31:0] exp_seq, input logic [8:0] chk,
                          input bit exp_done);
    int          en0, dn0, cl0, pushed;
    bit          ok;
    logic [7:0]  w;
    logic [31:0] mask;
`ifdef CONFIG_CHAIN_CRC_EN
    logic [7:0]  crc;
    crc = 8'h00;
`endif
    en0 = en_cnt[i]; dn0 = done_cnt[i]; cl0 = clr_cnt[i]; pushed = 0;
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
    check("start_clears_error", err_w[i], 1'b0);
    check("busy_after_start", busy_w[i], 1'b1);
    for (int k = 0; k < nw; k++) begin
      wait_ready(i, ok);
      check("ready_timeout", ok, 1'b1);
      if (k > 0) begin
        for (int s = 0; s < stall; s++) begin
          check("stall_ready", ready_w[i], 1'b1);
          check("stall_enable", en_w[i], 1'b0);
          tick();
        end
      end
      w = words[23 - 8 * k -: 8];
      for (int b = 7; b >= 0; b--) begin
        if (pushed < cl_of(i)) begin
          exp_q[i].push_back(w[b]);
`ifdef CONFIG_CHAIN_CRC_EN
          crc = crc_bit(crc, w[b]);
`endif
          pushed++;
        end
      end
      present(i, w);
    end
`ifdef CONFIG_CHAIN_CRC_EN
    wait_ready(i, ok);
    check("check_ready_timeout", ok, 1'b1);
    valid_s[i] = 1'b1;
    data_s[i]  = chk[8] ? chk[7:0] : crc;
    tick();
    valid_s[i] = 1'b0;
`endif
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (busy_w[i] === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("idle_timeout", ok, 1'b1);
    tick();
    mask = (32'd1 << exp_en) - 32'd1;
    check("enabled_bits", en_cnt[i] - en0, exp_en);
    check("bit_sequence", cap[i] & mask, exp_seq);
    check("bits_left", exp_q[i].size(), 0);
    check("clear_cycles", clr_cnt[i] - cl0, 1);
    check("done_pulses", done_cnt[i] - dn0, exp_done);
    check("error_flag", err_w[i], !exp_done);
    check("busy_after_load", busy_w[i], 1'b0);
  endtask

  initial begin
    bit ok;
    int en0, cl0;
    vecs[0] = '{0, 2, 24'hA53C00, 0, 16, 32'h0000A53C};
    vecs[1] = '{0, 2, 24'h00FF00, 0, 16, 32'h000000FF};
    vecs[2] = '{1, 3, 24'hFF00B7, 0, 20, 32'h000FF00B};
    vecs[3] = '{0, 2, 24'hA53C00, 5, 16, 32'h0000A53C};
    vecs[4] = '{1, 3, 24'h123456, 2, 20, 32'h00012345};
    vecs[5] = '{2, 1, 24'h010000, 0, 8,  32'h00000001};

    nreset = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; valid_s[i] = 1'b0; data_s[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++)
      check("reset_outputs", {ready_w[i], cfg_nreset_w[i], en_w[i], data_w[i], busy_w[i], done_w[i], err_w[i]},
            7'b0100000);
    nreset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < NDUT; i++) begin
        check("idle_busy", busy_w[i], 1'b0);
        check("idle_enable", en_w[i], 1'b0);
      end
    end

    for (int v = 0; v < 6; v++)
      run_load(vecs[v].dut, vecs[v].nw, vecs[v].words, vecs[v].stall, vecs[v].exp_en, vecs[v].exp_seq,
               9'h000, 1'b1);

    // Abort on the third shifted bit of the first word
    en0 = en_cnt[0];
    start_s[0] = 1'b1; tick(); start_s[0] = 1'b0;
    wait_ready(0, ok);
    check("abort_ready_timeout", ok, 1'b1);
    exp_q[0].push_back(1'b1); exp_q[0].push_back(1'b0); exp_q[0].push_back(1'b1);
    present(0, 8'hA5);
    tick(); tick();
    abort_s[0] = 1'b1; tick(); abort_s[0] = 1'b0;
    check("abort_error", err_w[0], 1'b1);
    check("abort_busy", busy_w[0], 1'b0);
    check("abort_enable", en_w[0], 1'b0);
    check("abort_ready", ready_w[0], 1'b0);
    check("abort_done", done_w[0], 1'b0);
    tick();
    check("abort_bits", en_cnt[0] - en0, 3);
    check("abort_bits_left", exp_q[0].size(), 0);
    check("abort_error_sticky", err_w[0], 1'b1);
    run_load(0, 2, 24'hA53C00, 0, 16, 32'h0000A53C, 9'h000, 1'b1);

    // start and abort together in IDLE: nothing starts
    cl0 = clr_cnt[0];
    start_s[0] = 1'b1; abort_s[0] = 1'b1; tick(); start_s[0] = 1'b0; abort_s[0] = 1'b0;
    check("idle_abort_busy", busy_w[0], 1'b0);
    check("idle_abort_error", err_w[0], 1'b0);
    tick();
    check("idle_abort_clear", clr_cnt[0] - cl0, 0);

    // Asynchronous reset in the middle of shifting
    start_s[1] = 1'b1; tick(); start_s[1] = 1'b0;
    wait_ready(1, ok);
    check("midreset_ready_timeout", ok, 1'b1);
    valid_s[1] = 1'b1; data_s[1] = 8'hFF; tick(); valid_s[1] = 1'b0;
    nreset = 1'b0;
    #1;
    check("midreset_outputs", {ready_w[1], cfg_nreset_w[1], en_w[1], data_w[1], busy_w[1], done_w[1], err_w[1]},
          7'b0100000);
    tick();
    nreset = 1'b1;
    tick();
    run_load(1, 3, 24'hFF00B7, 0, 20, 32'h000FF00B, 9'h000, 1'b1);

`ifdef CONFIG_CHAIN_CRC_EN
    run_load(2, 1, 24'h010000, 0, 8, 32'h00000001, 9'h107, 1'b1);
    run_load(2, 1, 24'h010000, 0, 8, 32'h00000001, 9'h108, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
